// File: rtl/sram_scan_chain_wrapper_if.sv
// ============================================================================
// Module  : sram_scan_chain_wrapper_if
// Brief   : Serial scan pin pair between chip scan pads and the SRAM wrapper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_scan_chain_wrapper_if;
    logic scan_in;
    logic scan_out;

    modport master (output scan_in, input scan_out);
    modport slave  (input scan_in, output scan_out);
endinterface

`default_nettype wire

// File: rtl/sram_scan_chain_wrapper.sv
// ============================================================================
// Module  : sram_scan_chain_wrapper
// Brief   : Bit-serial header/data front end owning an SRAM array (write/read).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_scan_chain_wrapper #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    sram_scan_chain_wrapper_if.slave      bus
);

    localparam int c_DEPTH     = 2 ** ADDR_W;
    localparam int c_FIELD_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_BW        = $clog2(c_FIELD_MAX);
    localparam int c_IW        = $clog2(DATA_W);
    localparam logic [c_BW-1:0] c_HDR_LAST  = c_BW'(ADDR_W - 1);
    localparam logic [c_BW-1:0] c_DATA_LAST = c_BW'(DATA_W - 1);
    localparam logic [c_IW-1:0] c_DATA_MSB  = c_IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_MODE  = 3'd0,
        S_CNT   = 3'd1,
        S_ADDR  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_word;
    logic [c_BW-1:0]     r_bit;
    logic [DATA_W-2:0]   r_shreg;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];

    logic                w_scan_in;
    logic                w_hdr_last;
    logic                w_frame_last;
    logic                w_word_last;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_wr_word;
    logic [DATA_W-1:0]   w_rd_word;
    logic [c_IW-1:0]     w_rd_idx;

    assign w_scan_in    = bus.scan_in;
    assign w_hdr_last   = (r_bit == c_HDR_LAST);
    assign w_frame_last = (r_bit == c_DATA_LAST);
    assign w_word_last  = (r_word == r_cnt);
    assign w_wr_word    = {r_shreg, w_scan_in};
    // Reset wins over a commit landing on the same edge.
    assign w_mem_we     = (r_state == S_WRITE) && w_frame_last && !rst;

    assign w_rd_word    = r_mem[r_addr];
    assign w_rd_idx     = c_DATA_MSB - r_bit[c_IW-1:0];
    assign bus.scan_out = (r_state == S_READ) ? w_rd_word[w_rd_idx] : 1'b0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MODE:  w_state_nxt = S_CNT;
            S_CNT:   if (w_hdr_last) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_hdr_last) w_state_nxt = r_is_write ? S_WRITE : S_READ;
            S_WRITE,
            S_READ:  if (w_frame_last && w_word_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_MODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_MODE;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_bit      <= '0;
            r_shreg    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_MODE: begin
                    r_is_write <= w_scan_in;
                    r_bit      <= '0;
                end
                S_CNT: begin
                    r_cnt <= {r_cnt[ADDR_W-2:0], w_scan_in};
                    r_bit <= w_hdr_last ? '0 : r_bit + 1'b1;
                end
                S_ADDR: begin
                    r_addr <= {r_addr[ADDR_W-2:0], w_scan_in};
                    r_bit  <= w_hdr_last ? '0 : r_bit + 1'b1;
                    r_word <= '0;
                end
                S_WRITE, S_READ: begin
                    if (r_state == S_WRITE)
                        r_shreg <= {r_shreg[DATA_W-3:0], w_scan_in};
                    // Frames are back to back; address wraps naturally at the top.
                    if (w_frame_last) begin
                        r_bit  <= '0;
                        r_addr <= r_addr + 1'b1;
                        r_word <= r_word + 1'b1;
                    end else begin
                        r_bit  <= r_bit + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset: contents survive across rst.
    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[r_addr] <= w_wr_word;
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_scan_chain_wrapper.sv
// ============================================================================
// Module  : tb_sram_scan_chain_wrapper
// Brief   : Self-checking bench with a word-array model of the scan SRAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_scan_chain_wrapper;

    localparam int c_AW    = 11;
    localparam int c_DEPTH = 2 ** c_AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_scan_chain_wrapper_if bus();

    sram_scan_chain_wrapper #(.ADDR_W(c_AW), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mdl_mem [0:c_DEPTH-1];
    bit         mdl_ok  [0:c_DEPTH-1];
    logic [7:0] wbuf    [0:15];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic drive(input logic b);
        bus.scan_in = b;
        @(negedge clk);
    endtask

    task automatic send_field(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(v[i]);
    endtask

    task automatic send_header(input logic wr, input int cnt, input int addr);
        drive(wr);
        send_field(cnt, c_AW);
        send_field(addr, c_AW);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.scan_in = 1'($urandom);
        @(negedge clk);
        check("rst_out", bus.scan_out, 0);
        rst = 1'b0;
    endtask

    // abort_bits < 0 runs the whole transfer; otherwise rst after that many data bits.
    task automatic do_write(input int addr, input int n, input int abort_bits);
        int lim;
        lim = (abort_bits < 0) ? n * 8 : abort_bits;
        send_header(1'b1, n - 1, addr);
        for (int k = 0; k < lim; k++) begin
            drive(wbuf[k / 8][7 - (k % 8)]);
            if (k % 8 == 7) begin
                mdl_mem[(addr + k / 8) % c_DEPTH] = wbuf[k / 8];
                mdl_ok[(addr + k / 8) % c_DEPTH]  = 1'b1;
                check("wr_out", bus.scan_out, 0);
            end
        end
        if (abort_bits < 0) begin
            for (int k = 0; k < 8; k++) begin
                drive(1'($urandom));
                check("done_wr_out", bus.scan_out, 0);
            end
        end
        do_reset();
    endtask

    task automatic do_read(input int addr, input int n, input int abort_bits);
        int lim;
        int a;
        logic [7:0] obs;
        lim = (abort_bits < 0) ? n * 8 : abort_bits;
        obs = '0;
        send_header(1'b0, n - 1, addr);
        for (int k = 0; k < lim; k++) begin
            obs = {obs[6:0], bus.scan_out};
            drive(1'($urandom));
            if (k % 8 == 7) begin
                a = (addr + k / 8) % c_DEPTH;
                if (mdl_ok[a]) check($sformatf("rd_word@%0h", a), obs, mdl_mem[a]);
            end
        end
        if (abort_bits < 0) begin
            for (int k = 0; k < 4; k++) begin
                check("done_rd_out", bus.scan_out, 0);
                drive(1'($urandom));
            end
        end
        do_reset();
    endtask

    initial begin
        int addr, n, ab, done_words;
        rst = 1'b1;
        bus.scan_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", bus.scan_out, 0);
        rst = 1'b0;

        // Whole-array header, five frames, then reset.
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C; wbuf[2] = 8'hFF; wbuf[3] = 8'h00; wbuf[4] = 8'h81;
        do_write(0, c_DEPTH, 40);
        do_read(0, 5, -1);

        // Address wrap in both directions.
        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        do_write(11'h7FF, 2, -1);
        do_read(11'h7FF, 2, -1);

        // Single word; trailing bits in DONE must not touch the neighbour.
        wbuf[0] = 8'h77;
        do_write(11'h011, 1, -1);
        wbuf[0] = 8'h5A;
        do_write(11'h010, 1, -1);
        do_read(11'h010, 2, -1);

        // Reset mid-frame and on the commit edge of the second frame.
        wbuf[0] = 8'hC3; wbuf[1] = 8'h96; wbuf[2] = 8'h69;
        do_write(11'h100, 3, -1);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        do_write(11'h100, 3, 12);
        do_read(11'h100, 3, -1);
        wbuf[0] = 8'h44; wbuf[1] = 8'h55;
        do_write(11'h101, 2, 15);
        do_read(11'h100, 3, -1);

        // Reset mid-read, then a clean restart.
        do_read(0, 5, 12);
        do_read(0, 5, -1);

        for (int it = 0; it < 20; it++) begin
            addr = int'($urandom_range(c_DEPTH - 1, 0));
            n    = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n * 8 - 1, 0)) : -1;
            do_write(addr, n, ab);
            done_words = (ab < 0) ? n : ab / 8;
            if (done_words > 0)
                do_read(addr, done_words,
                        ($urandom_range(3, 0) == 0) ? int'($urandom_range(done_words * 8 - 1, 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
